// File: rtl/pipe_skid_reg_pkg.sv
// Shared types and widths for the elastic pipeline register.
package pipe_skid_reg_pkg;

  localparam int unsigned COUNT_W = 2;

  typedef enum logic [COUNT_W-1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } skid_state_e;

endpackage

// File: rtl/pipe_skid_reg_slot.sv
// Single storage slot: valid bit plus payload register; clear wins over load.
module pipe_slot #(
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr_i,
  input  logic              ld_i,
  input  logic [DATA_W-1:0] d_i,
  output logic              valid_o,
  output logic [DATA_W-1:0] data_o
);

  logic              valid_q;
  logic [DATA_W-1:0] data_q;

  // Clearing zeroes the payload too, so an empty slot always reads 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else if (clr_i) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else if (ld_i) begin
      valid_q <= 1'b1;
      data_q  <= d_i;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule

// File: rtl/pipe_skid_reg.sv
// Elastic inter-stage register with valid/ready, stall/flush and optional skid slot.
module pipe_skid_reg
  import pipe_skid_reg_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned SKID   = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               stall,
  input  logic               up_valid,
  output logic               up_ready,
  input  logic [DATA_W-1:0]  up_data,
  output logic               dn_valid,
  input  logic               dn_ready,
  output logic [DATA_W-1:0]  dn_data,
  output logic [COUNT_W-1:0] count
);

  logic              acc;
  logic              adv;
  logic              main_ld;
  logic              main_clr;
  logic [DATA_W-1:0] main_d;

  assign acc = up_valid & up_ready;
  assign adv = dn_valid & dn_ready & ~stall;

  pipe_slot #(.DATA_W(DATA_W)) u_main (
    .clk     (clk),
    .rst     (rst),
    .clr_i   (main_clr),
    .ld_i    (main_ld),
    .d_i     (main_d),
    .valid_o (dn_valid),
    .data_o  (dn_data)
  );

  if (SKID == 0) begin : g_single
    assign up_ready = ~dn_valid | adv;
    assign main_ld  = acc & ~flush;
    assign main_clr = flush | (adv & ~acc);
    assign main_d   = up_data;
    assign count    = {1'b0, dn_valid};
  end else begin : g_skid
    skid_state_e       state_q;
    skid_state_e       state_d;
    logic              skid_ld;
    logic              skid_clr;
    logic              skid_valid;
    logic [DATA_W-1:0] skid_data;

    pipe_slot #(.DATA_W(DATA_W)) u_skid (
      .clk     (clk),
      .rst     (rst),
      .clr_i   (skid_clr),
      .ld_i    (skid_ld),
      .d_i     (up_data),
      .valid_o (skid_valid),
      .data_o  (skid_data)
    );

    always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= ST_EMPTY;
      else     state_q <= state_d;
    end

    // Occupancy state steers which slot loads; TWO never accepts since up_ready is low.
    always_comb begin
      state_d  = state_q;
      main_ld  = 1'b0;
      main_clr = 1'b0;
      main_d   = up_data;
      skid_ld  = 1'b0;
      skid_clr = 1'b0;
      if (flush) begin
        state_d  = ST_EMPTY;
        main_clr = 1'b1;
        skid_clr = 1'b1;
      end else begin
        unique case (state_q)
          ST_EMPTY: begin
            if (acc) begin
              main_ld = 1'b1;
              state_d = ST_ONE;
            end
          end
          ST_ONE: begin
            if (acc && adv) begin
              main_ld = 1'b1;
            end else if (acc) begin
              skid_ld = 1'b1;
              state_d = ST_TWO;
            end else if (adv) begin
              main_clr = 1'b1;
              state_d  = ST_EMPTY;
            end
          end
          ST_TWO: begin
            if (adv) begin
              main_ld  = 1'b1;
              main_d   = skid_data;
              skid_clr = 1'b1;
              state_d  = ST_ONE;
            end
          end
          default: begin
            state_d  = ST_EMPTY;
            main_clr = 1'b1;
            skid_clr = 1'b1;
          end
        endcase
      end
    end

    assign up_ready = ~skid_valid;
    assign count    = COUNT_W'(state_q);
  end

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Scoreboard bench: A = 32-bit skid variant, B = 73-bit single-slot variant.
module tb_pipe_skid_reg;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        a_flush = 0, a_stall = 0, a_up_valid = 0, a_dn_ready = 0;
  logic        a_up_ready, a_dn_valid;
  logic [31:0] a_up_data = '0, a_dn_data;
  logic [1:0]  a_count;

  logic        b_flush = 0, b_stall = 0, b_up_valid = 0, b_dn_ready = 0;
  logic        b_up_ready, b_dn_valid;
  logic [72:0] b_up_data = '0, b_dn_data;
  logic [1:0]  b_count;

  pipe_skid_reg #(.DATA_W(32), .SKID(1)) u_dut_a (
    .clk(clk), .rst(rst), .flush(a_flush), .stall(a_stall),
    .up_valid(a_up_valid), .up_ready(a_up_ready), .up_data(a_up_data),
    .dn_valid(a_dn_valid), .dn_ready(a_dn_ready), .dn_data(a_dn_data),
    .count(a_count)
  );

  pipe_skid_reg #(.DATA_W(73), .SKID(0)) u_dut_b (
    .clk(clk), .rst(rst), .flush(b_flush), .stall(b_stall),
    .up_valid(b_up_valid), .up_ready(b_up_ready), .up_data(b_up_data),
    .dn_valid(b_dn_valid), .dn_ready(b_dn_ready), .dn_data(b_dn_data),
    .count(b_count)
  );

  logic [31:0] qa[$];
  logic [72:0] qb[$];
  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Drive one cycle; expected beats are queued only when actually accepted.
  task automatic cyc_a(input logic v, input logic [31:0] d, input logic r,
                       input logic s, input logic f);
    a_up_valid = v; a_up_data = d; a_dn_ready = r; a_stall = s; a_flush = f;
    @(negedge clk);
    if (v && a_up_ready && !f) qa.push_back(d);
    @(posedge clk); #1;
    if (f) qa.delete();
  endtask

  task automatic cyc_b(input logic v, input logic [72:0] d, input logic r,
                       input logic s, input logic f);
    b_up_valid = v; b_up_data = d; b_dn_ready = r; b_stall = s; b_flush = f;
    @(negedge clk);
    if (v && b_up_ready && !f) qb.push_back(d);
    @(posedge clk); #1;
    if (f) qb.delete();
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (a_dn_valid && a_dn_ready && !a_stall) begin
        if (qa.size() == 0) chk("A_unexpected_beat", 128'(a_dn_data), 128'hDEAD);
        else chk("A_data", 128'(a_dn_data), 128'(qa.pop_front()));
      end else if (!a_dn_valid) begin
        chk("A_bubble", 128'(a_dn_data), 128'd0);
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (b_dn_valid && b_dn_ready && !b_stall) begin
        if (qb.size() == 0) chk("B_unexpected_beat", 128'(b_dn_data), 128'hDEAD);
        else chk("B_data", 128'(b_dn_data), 128'(qb.pop_front()));
      end else if (!b_dn_valid) begin
        chk("B_bubble", 128'(b_dn_data), 128'd0);
      end
    end
  end

  initial begin
    logic [31:0] av;
    logic [72:0] bv;
    logic [72:0] bs;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("A_rst_valid", 128'(a_dn_valid), 128'd0);
    chk("A_rst_count", 128'(a_count), 128'd0);
    chk("A_rst_ready", 128'(a_up_ready), 128'd1);
    chk("B_rst_valid", 128'(b_dn_valid), 128'd0);
    chk("B_rst_ready", 128'(b_up_ready), 128'd1);

    // Streaming 0x11..0x88 on A.
    for (int i = 1; i <= 8; i++) begin
      av = 32'(i * 'h11);
      cyc_a(1'b1, av, 1'b1, 1'b0, 1'b0);
      chk("A_stream_count", 128'(a_count), 128'd1);
      chk("A_stream_valid", 128'(a_dn_valid), 128'd1);
    end
    cyc_a(1'b0, 32'd0, 1'b1, 1'b0, 1'b0);
    chk("A_drain_count", 128'(a_count), 128'd0);

    // Backpressure: two slots fill, third beat held upstream.
    cyc_a(1'b1, 32'hA1, 1'b0, 1'b0, 1'b0);
    cyc_a(1'b1, 32'hA2, 1'b0, 1'b0, 1'b0);
    cyc_a(1'b1, 32'hA3, 1'b0, 1'b0, 1'b0);
    chk("A_bp_count", 128'(a_count), 128'd2);
    chk("A_bp_ready", 128'(a_up_ready), 128'd0);
    chk("A_bp_head", 128'(a_dn_data), 128'hA1);
    cyc_a(1'b1, 32'hA3, 1'b1, 1'b0, 1'b0);
    chk("A_bp_ready_back", 128'(a_up_ready), 128'd1);
    chk("A_bp_count1", 128'(a_count), 128'd1);
    cyc_a(1'b1, 32'hA3, 1'b1, 1'b0, 1'b0);
    cyc_a(1'b0, 32'd0, 1'b1, 1'b0, 1'b0);
    chk("A_bp_empty", 128'(a_count), 128'd0);

    // Stall holds 0xB1 even with dn_ready high.
    cyc_a(1'b1, 32'hB1, 1'b0, 1'b0, 1'b0);
    repeat (3) begin
      cyc_a(1'b0, 32'd0, 1'b1, 1'b1, 1'b0);
      chk("A_stall_data", 128'(a_dn_data), 128'hB1);
      chk("A_stall_valid", 128'(a_dn_valid), 128'd1);
    end
    cyc_a(1'b0, 32'd0, 1'b1, 1'b0, 1'b0);

    // Flush with both slots full and 0xC3 offered.
    cyc_a(1'b1, 32'hC1, 1'b0, 1'b0, 1'b0);
    cyc_a(1'b1, 32'hC2, 1'b0, 1'b0, 1'b0);
    chk("A_fl_count2", 128'(a_count), 128'd2);
    cyc_a(1'b1, 32'hC3, 1'b0, 1'b1, 1'b1);
    chk("A_fl_valid", 128'(a_dn_valid), 128'd0);
    chk("A_fl_data", 128'(a_dn_data), 128'd0);
    chk("A_fl_count", 128'(a_count), 128'd0);
    chk("A_fl_ready", 128'(a_up_ready), 128'd1);
    // Flush coinciding with advance and accept.
    cyc_a(1'b1, 32'hC4, 1'b0, 1'b0, 1'b0);
    cyc_a(1'b1, 32'hC5, 1'b1, 1'b0, 1'b1);
    chk("A_fl2_count", 128'(a_count), 128'd0);
    cyc_a(1'b0, 32'd0, 1'b1, 1'b0, 1'b0);

    // Async reset mid-cycle with count 2.
    cyc_a(1'b1, 32'hD1, 1'b0, 1'b0, 1'b0);
    cyc_a(1'b1, 32'hD2, 1'b0, 1'b0, 1'b0);
    chk("A_pre_rst_count", 128'(a_count), 128'd2);
    rst = 1'b1;
    #2;
    chk("A_mid_rst_valid", 128'(a_dn_valid), 128'd0);
    chk("A_mid_rst_data", 128'(a_dn_data), 128'd0);
    chk("A_mid_rst_count", 128'(a_count), 128'd0);
    chk("A_mid_rst_ready", 128'(a_up_ready), 128'd1);
    qa.delete();
    qb.delete();
    @(posedge clk); #1 rst = 1'b0;
    a_up_valid = 1'b0;

    // B: streaming, stall, bubble, flush.
    for (int i = 1; i <= 4; i++) begin
      bv = {9'(i), 64'h0123_4567_89AB_CDEF};
      cyc_b(1'b1, bv, 1'b1, 1'b0, 1'b0);
      chk("B_stream_ready", 128'(b_up_ready), 128'd1);
      chk("B_stream_count", 128'(b_count), 128'd1);
    end
    cyc_b(1'b0, 73'd0, 1'b1, 1'b0, 1'b0);
    chk("B_drain_valid", 128'(b_dn_valid), 128'd0);
    chk("B_drain_data", 128'(b_dn_data), 128'd0);
    bs = {9'h1AB, 64'hFEED_FACE_CAFE_BEEF};
    cyc_b(1'b1, bs, 1'b0, 1'b0, 1'b0);
    chk("B_noready_up_ready", 128'(b_up_ready), 128'd0);
    repeat (3) begin
      cyc_b(1'b0, 73'd0, 1'b1, 1'b1, 1'b0);
      chk("B_stall_up_ready", 128'(b_up_ready), 128'd0);
      chk("B_stall_data", 128'(b_dn_data), 128'(bs));
    end
    cyc_b(1'b0, 73'd0, 1'b1, 1'b0, 1'b0);
    chk("B_bubble_valid", 128'(b_dn_valid), 128'd0);
    chk("B_bubble_data", 128'(b_dn_data), 128'd0);
    cyc_b(1'b1, 73'h0F1, 1'b0, 1'b0, 1'b0);
    cyc_b(1'b1, 73'h0F2, 1'b1, 1'b0, 1'b1);
    chk("B_fl_valid", 128'(b_dn_valid), 128'd0);
    chk("B_fl_data", 128'(b_dn_data), 128'd0);
    chk("B_fl_count", 128'(b_count), 128'd0);
    cyc_b(1'b0, 73'd0, 1'b1, 1'b0, 1'b0);

    // Random soak on both instances.
    for (int i = 0; i < 400; i++) begin
      av = $urandom();
      bv = 73'({$urandom(), $urandom(), $urandom()});
      fork
        cyc_a($urandom_range(0, 3) != 0, av, $urandom_range(0, 2) != 0,
              $urandom_range(0, 5) == 0, $urandom_range(0, 39) == 0);
        cyc_b($urandom_range(0, 3) != 0, bv, $urandom_range(0, 2) != 0,
              $urandom_range(0, 5) == 0, $urandom_range(0, 39) == 0);
      join
    end
    repeat (6) begin
      fork
        cyc_a(1'b0, 32'd0, 1'b1, 1'b0, 1'b0);
        cyc_b(1'b0, 73'd0, 1'b1, 1'b0, 1'b0);
      join
    end
    chk("A_no_loss", 128'(qa.size()), 128'd0);
    chk("B_no_loss", 128'(qb.size()), 128'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
